// File: rtl/rsa_pkg.sv
// rsa_pkg -- shared definitions for the RSA request arbiter.
//   rsa_state_e     : job FSM encoding (IDLE, LAUNCH, WAIT, RESP)
//   RSA_DEF_*       : default exponent width, requester count, job timeout
//   rsa_idw()       : requester-index width, never below 1 bit
//   rsa_cnt_w()     : width of a counter able to hold 0..TIMEOUT
package rsa_pkg;

  localparam int RSA_DEF_WIDTH   = 512;
  localparam int RSA_DEF_NREQ    = 4;
  localparam int RSA_DEF_TIMEOUT = 65535;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } rsa_state_e;

  function automatic int rsa_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rsa_cnt_w(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- combinational round-robin pick.
//   req   in  N    request vector
//   ptr   in  IDW  highest-priority index this cycle
//   grant out N    one-hot grant (zero when no request)
//   idx   out IDW  index of the granted bit
//   any   out 1    at least one request present
// Scans ptr, ptr+1, ... wrapping at N; the first set request wins.
module rr_arbiter
  import rsa_pkg::*;
#(
  parameter  int N   = RSA_DEF_NREQ,
  localparam int IDW = rsa_idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/rsa_req_arbiter.sv
// rsa_req_arbiter -- shares one external modexp engine among NREQ requesters.
//   aclk, aresetn             clock, synchronous active-low reset
//   req_valid/req_ready       per-requester job handshake (ready one-hot or zero)
//   req_data/req_exp/req_mod  packed operand slots, slot i at [i*W +: W]
//   eng_start                 one-cycle launch pulse to the engine
//   eng_data/eng_exp/eng_mod  operands held stable for the whole job
//   eng_done/eng_result       engine completion pulse and result
//   rsp_valid/rsp_ready       response handshake
//   rsp_data/rsp_id/rsp_err   result (zero on error), owner index, abort flag
//   dbg_state                 current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// 1. A producer holding valid keeps its payload stable until that edge; ready
// may be given or withheld freely. req_ready is combinational from the IDLE
// state and req_valid; rsp_valid is high only in RESP.
module rsa_req_arbiter
  import rsa_pkg::*;
#(
  parameter  int WIDTH   = RSA_DEF_WIDTH,
  parameter  int NREQ    = RSA_DEF_NREQ,
  parameter  int TIMEOUT = RSA_DEF_TIMEOUT,
  localparam int DW      = 4 * WIDTH,
  localparam int IDW     = rsa_idw(NREQ)
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ*WIDTH-1:0] req_exp,
  input  logic [NREQ*DW-1:0] req_mod,
  output logic               eng_start,
  output logic [DW-1:0]      eng_data,
  output logic [WIDTH-1:0]   eng_exp,
  output logic [DW-1:0]      eng_mod,
  input  logic               eng_done,
  input  logic [DW-1:0]      eng_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DW-1:0]      rsp_data,
  output logic [IDW-1:0]     rsp_id,
  output logic               rsp_err,
  output rsa_state_e         dbg_state
);

  localparam int CW = rsa_cnt_w(TIMEOUT);

  rsa_state_e       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [DW-1:0]    eng_data_q, eng_data_d;
  logic [WIDTH-1:0] eng_exp_q, eng_exp_d;
  logic [DW-1:0]    eng_mod_q, eng_mod_d;
  logic [DW-1:0]    rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic [NREQ-1:0]  arb_grant;
  logic [IDW-1:0]   arb_idx;
  logic             arb_any;
  logic             mod_trivial;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Modulus 0 or 1 has no meaningful modexp; reject without using the engine.
  assign mod_trivial = (eng_mod_q[DW-1:1] == '0);

  // Gated by aresetn so no requester sees a grant while reset is applied.
  assign req_ready = arb_grant & {NREQ{(state_q == ST_IDLE) && aresetn}};
  assign eng_start = (state_q == ST_LAUNCH) && !mod_trivial;
  assign rsp_valid = (state_q == ST_RESP);

  assign eng_data  = eng_data_q;
  assign eng_exp   = eng_exp_q;
  assign eng_mod   = eng_mod_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = id_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    eng_data_d = eng_data_q;
    eng_exp_d  = eng_exp_q;
    eng_mod_d  = eng_mod_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          id_d       = arb_idx;
          rr_ptr_d   = (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + IDW'(1);
          eng_data_d = req_data[int'(arb_idx) * DW +: DW];
          eng_exp_d  = req_exp[int'(arb_idx) * WIDTH +: WIDTH];
          eng_mod_d  = req_mod[int'(arb_idx) * DW +: DW];
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          state_d    = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        if (mod_trivial) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = ST_RESP;
        end else begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (eng_done) begin
          rsp_data_d = eng_result;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else begin
          // cnt_d equals the number of WAIT cycles spent so far.
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(TIMEOUT)) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      id_q       <= '0;
      eng_data_q <= '0;
      eng_exp_q  <= '0;
      eng_mod_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      eng_data_q <= eng_data_d;
      eng_exp_q  <= eng_exp_d;
      eng_mod_q  <= eng_mod_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_rsa_req_arbiter.sv
// tb_rsa_req_arbiter -- directed bench for rsa_req_arbiter with a stub engine.
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_rsa_req_arbiter;
  import rsa_pkg::*;

  localparam int W   = 8;
  localparam int DW  = 4 * W;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 100;

  logic               aclk;
  logic               aresetn;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*DW-1:0]    req_data;
  logic [N*W-1:0]     req_exp;
  logic [N*DW-1:0]    req_mod;
  logic               eng_start;
  logic [DW-1:0]      eng_data;
  logic [W-1:0]       eng_exp;
  logic [DW-1:0]      eng_mod;
  logic               eng_done;
  logic [DW-1:0]      eng_result;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DW-1:0]      rsp_data;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_err;
  rsa_state_e         dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  rsa_req_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(TO)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_exp    (req_exp),
    .req_mod    (req_mod),
    .eng_start  (eng_start),
    .eng_data   (eng_data),
    .eng_exp    (eng_exp),
    .eng_mod    (eng_mod),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- stub engine ----------------
  // Returns stub_res (fixed mode) or eng_data+1 stub_lat falling edges after
  // it sees eng_start. stray_done injects an unsolicited completion.
  logic          stub_en, stub_fixed, stub_busy, stub_done, stray_done;
  int            stub_lat, stub_cnt, start_count;
  logic [DW-1:0] stub_res;

  assign eng_done = stub_done | stray_done;

  always @(negedge aclk) begin
    stub_done  = 1'b0;
    eng_result = '0;
    if (!aresetn) begin
      stub_busy = 1'b0;
    end else begin
      if (stub_busy) begin
        stub_cnt++;
        if (stub_cnt == stub_lat) begin
          stub_done  = 1'b1;
          eng_result = stub_fixed ? stub_res : eng_data + 32'd1;
          stub_busy  = 1'b0;
        end
      end else if (eng_start && stub_en) begin
        stub_busy = 1'b1;
        stub_cnt  = 0;
      end
      if (eng_start) start_count++;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic set_slot(input int i, input logic [DW-1:0] d,
                          input logic [W-1:0] e, input logic [DW-1:0] m);
    req_data[i*DW +: DW] = d;
    req_exp[i*W +: W]    = e;
    req_mod[i*DW +: DW]  = m;
  endtask

  task automatic wait_rsp(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles < budget) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge aclk); #1;
      cycles++;
    end
  endtask

  function automatic int oh2idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    aresetn    = 1'b0;
    rsp_ready  = 1'b1;
    stray_done = 1'b0;
    stub_en    = 1'b1;
    stub_fixed = 1'b0;
    stub_lat   = 2;
    stub_res   = '0;
    start_count = 0;
    stub_busy  = 1'b0;
    stub_cnt   = 0;
    req_data   = '0;
    req_exp    = '0;
    req_mod    = '0;
    for (int i = 0; i < N; i++) set_slot(i, 32'(256 + 16 * i), 8'd3, 32'd33);
    req_valid = 4'hF;
    repeat (3) @(negedge aclk);
    #1;
    n_cmp++; if (req_ready !== 4'h0) begin n_bad++; $display("FAIL reset_req_ready: got %0h want 0", req_ready); end
    n_cmp++; if (eng_start !== 1'b0) begin n_bad++; $display("FAIL reset_eng_start: got %0b want 0", eng_start); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err: got %0b want 0", rsp_err); end
    n_cmp++; if (rsp_data !== 32'd0) begin n_bad++; $display("FAIL reset_rsp_data: got %0h want 0", rsp_data); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    n_cmp++; if ({eng_data, eng_exp, eng_mod} !== '0) begin n_bad++; $display("FAIL reset_eng_ops: got %0h/%0h/%0h want 0", eng_data, eng_exp, eng_mod); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_rr_order;
    int exp_q[$];
    int g_idx[$];
    int r_id[$];
    logic [DW-1:0] r_dat[$];
    int grants, resp, viol;
    logic [N-1:0] prev;
    exp_q = '{0, 1, 2, 3, 0};
    grants = 0; resp = 0; viol = 0; prev = '0;
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    for (int cyc = 0; cyc < 300 && resp < 5; cyc++) begin
      if (req_ready !== '0) begin
        if (!$onehot(req_ready) || prev !== '0) viol++;
        if (grants < 5) g_idx.push_back(oh2idx(req_ready));
        grants++;
      end
      if (rsp_valid === 1'b1 && rsp_ready) begin
        r_id.push_back(int'(rsp_id));
        r_dat.push_back(rsp_data);
        resp++;
      end
      prev = req_ready;
      @(negedge aclk);
      if (grants >= 5) req_valid = '0;
      #1;
    end
    n_cmp++; if (grants !== 5) begin n_bad++; $display("FAIL rr_grant_count: got %0d want 5", grants); end
    n_cmp++; if (resp !== 5) begin n_bad++; $display("FAIL rr_rsp_count: got %0d want 5", resp); end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL rr_ready_pulse: got %0d bad cycles want 0", viol); end
    for (int i = 0; i < 5; i++) begin
      if (i < g_idx.size()) begin
        n_cmp++; if (g_idx[i] !== exp_q[i]) begin n_bad++; $display("FAIL rr_grant_%0d: got %0d want %0d", i, g_idx[i], exp_q[i]); end
      end
      if (i < r_id.size()) begin
        n_cmp++; if (r_id[i] !== exp_q[i]) begin n_bad++; $display("FAIL rr_rsp_id_%0d: got %0d want %0d", i, r_id[i], exp_q[i]); end
        n_cmp++; if (r_dat[i] !== 32'(256 + 16 * exp_q[i] + 1)) begin n_bad++; $display("FAIL rr_rsp_data_%0d: got %0h want %0h", i, r_dat[i], 256 + 16 * exp_q[i] + 1); end
      end
    end
  endtask

  task automatic test_single_job;
    int cyc;
    bit ok;
    set_slot(2, 32'd5, 8'd3, 32'd33);
    stub_en = 1'b1; stub_fixed = 1'b1; stub_res = 32'd26; stub_lat = 10;
    rsp_ready = 1'b1;
    @(negedge aclk); req_valid = 4'b0100; #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_grant: got %0b want 0100", req_ready); end
    @(negedge aclk); req_valid = '0; #1;
    n_cmp++; if (eng_start !== 1'b1) begin n_bad++; $display("FAIL single_eng_start: got %0b want 1", eng_start); end
    n_cmp++; if ({eng_data, eng_exp, eng_mod} !== {32'd5, 8'd3, 32'd33}) begin n_bad++; $display("FAIL single_eng_ops: got %0d/%0d/%0d want 5/3/33", eng_data, eng_exp, eng_mod); end
    wait_rsp(40, cyc, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL single_rsp_timeout: got no rsp_valid within %0d cycles want rsp_valid", cyc); end
    n_cmp++; if (rsp_data !== 32'd26) begin n_bad++; $display("FAIL single_rsp_data: got %0d want 26", rsp_data); end
    n_cmp++; if (rsp_id !== 2'd2) begin n_bad++; $display("FAIL single_rsp_id: got %0d want 2", rsp_id); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL single_rsp_err: got %0b want 0", rsp_err); end
    @(negedge aclk); #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_rsp_drop: got %0b want 0", rsp_valid); end
  endtask

  task automatic test_timeout;
    int waits;
    stub_en = 1'b0;
    set_slot(1, 32'd9, 8'd3, 32'd33);
    // Pointer sits at 3 after the previous grant of slot 2: must wrap to 1.
    @(negedge aclk); req_valid = 4'b0010; #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL to_grant: got %0b want 0010", req_ready); end
    @(negedge aclk); req_valid = '0; #1;
    n_cmp++; if (eng_start !== 1'b1) begin n_bad++; $display("FAIL to_eng_start: got %0b want 1", eng_start); end
    waits = 0;
    for (int cyc = 0; cyc < 200 && rsp_valid !== 1'b1; cyc++) begin
      @(negedge aclk); #1;
      if (dbg_state == ST_WAIT) waits++;
    end
    n_cmp++; if (waits !== TO) begin n_bad++; $display("FAIL to_wait_cycles: got %0d want %0d", waits, TO); end
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL to_rsp_valid: got %0b want 1", rsp_valid); end
    n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL to_rsp_err: got %0b want 1", rsp_err); end
    n_cmp++; if (rsp_data !== 32'd0) begin n_bad++; $display("FAIL to_rsp_data: got %0h want 0", rsp_data); end
    n_cmp++; if (rsp_id !== 2'd1) begin n_bad++; $display("FAIL to_rsp_id: got %0d want 1", rsp_id); end
    @(negedge aclk); #1;
  endtask

  task automatic test_bad_mod;
    int slot, sc0;
    logic [DW-1:0] m;
    logic [N-1:0] oh;
    for (int k = 0; k < 2; k++) begin
      slot = (k == 0) ? 3 : 0;
      m    = (k == 0) ? 32'd1 : 32'd0;
      oh   = N'(1) << slot;
      set_slot(slot, 32'd77, 8'd3, m);
      sc0 = start_count;
      @(negedge aclk); req_valid = oh; #1;
      n_cmp++; if (req_ready !== oh) begin n_bad++; $display("FAIL badmod%0d_grant: got %0b want %0b", k, req_ready, oh); end
      @(negedge aclk); req_valid = '0; #1;
      n_cmp++; if ({eng_start, rsp_valid} !== 2'b00) begin n_bad++; $display("FAIL badmod%0d_launch: got start=%0b valid=%0b want 0/0", k, eng_start, rsp_valid); end
      @(negedge aclk); #1;
      n_cmp++; if ({rsp_valid, rsp_err} !== 2'b11) begin n_bad++; $display("FAIL badmod%0d_rsp: got valid=%0b err=%0b want 1/1", k, rsp_valid, rsp_err); end
      n_cmp++; if (rsp_data !== 32'd0) begin n_bad++; $display("FAIL badmod%0d_data: got %0h want 0", k, rsp_data); end
      n_cmp++; if (int'(rsp_id) !== slot) begin n_bad++; $display("FAIL badmod%0d_id: got %0d want %0d", k, rsp_id, slot); end
      n_cmp++; if (start_count !== sc0) begin n_bad++; $display("FAIL badmod%0d_no_start: got %0d starts want 0", k, start_count - sc0); end
      @(negedge aclk); #1;
    end
  endtask

  task automatic test_backpressure;
    int cyc, viol;
    bit ok;
    rsp_ready = 1'b0;
    stub_en = 1'b1; stub_fixed = 1'b0; stub_lat = 3;
    set_slot(0, 32'd7, 8'd3, 32'd33);
    @(negedge aclk); req_valid = 4'b0001; #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_grant: got %0b want 0001", req_ready); end
    @(negedge aclk); req_valid = 4'hF; #1;
    wait_rsp(40, cyc, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bp_rsp_timeout: got no rsp_valid within %0d cycles want rsp_valid", cyc); end
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd8 || rsp_id !== 2'd0 || rsp_err !== 1'b0 ||
          req_ready !== '0 || eng_start !== 1'b0) viol++;
    end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", viol); end
    rsp_ready = 1'b1;
    @(negedge aclk); #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: got %0b want 0", rsp_valid); end
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_next_grant: got %0b want 0010", req_ready); end
    req_valid = '0;
    @(negedge aclk); #1;
  endtask

  task automatic test_reset_mid_job;
    int viol;
    stub_en = 1'b0;
    set_slot(2, 32'd11, 8'd3, 32'd33);
    @(negedge aclk); req_valid = 4'b0100;
    @(negedge aclk); req_valid = '0;
    @(negedge aclk); #1;
    n_cmp++; if (dbg_state !== ST_WAIT) begin n_bad++; $display("FAIL mid_in_wait: got %0d want %0d", dbg_state, ST_WAIT); end
    @(negedge aclk); aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk); stray_done = 1'b1;
    @(negedge aclk); stray_done = 1'b0;
    viol = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk); #1;
      if (rsp_valid !== 1'b0 || dbg_state !== ST_IDLE || eng_start !== 1'b0) viol++;
    end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL mid_no_rsp: got %0d active cycles want 0", viol); end
    n_cmp++; if ({rsp_data, rsp_id, rsp_err} !== '0) begin n_bad++; $display("FAIL mid_rsp_fields: got %0h/%0d/%0b want 0", rsp_data, rsp_id, rsp_err); end
    n_cmp++; if ({eng_data, eng_exp, eng_mod} !== '0) begin n_bad++; $display("FAIL mid_eng_ops: got %0h/%0h/%0h want 0", eng_data, eng_exp, eng_mod); end
    n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL mid_req_ready: got %0b want 0", req_ready); end
  endtask

  initial begin
    test_reset();
    test_rr_order();
    test_single_job();
    test_timeout();
    test_bad_mod();
    test_backpressure();
    test_reset_mid_job();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rsa_req_arbiter.md
RSA_REQ_ARBITER -- requirements
Module: rsa_req_arbiter

Interface
REQ-001 Parameter WIDTH, default 512, exponent width; data/modulus/result width is 4*WIDTH.
REQ-002 Parameter NREQ, default 4, number of requesters; IDW = max(1, clog2(NREQ)).
REQ-003 Parameter TIMEOUT, default 65535, maximum engine cycles per job before abort.
REQ-004 Reset is aresetn, synchronous, active-low; clock is aclk.
REQ-005 aclk  in  1  clock; all state changes on rising edge.
REQ-006 aresetn  in  1  synchronous active-low reset.
REQ-007 req_valid  in  NREQ  per-requester job valid.
REQ-008 req_ready  out  NREQ  per-requester job accept; one-hot or zero.
REQ-009 req_data  in  NREQ*4*WIDTH  message per requester; slot i at bits [i*4*WIDTH +: 4*WIDTH].
REQ-010 req_exp  in  NREQ*WIDTH  public exponent per requester; slot i at [i*WIDTH +: WIDTH].
REQ-011 req_mod  in  NREQ*4*WIDTH  modulus per requester; slot i at bits [i*4*WIDTH +: 4*WIDTH].
REQ-012 eng_start  out  1  one-cycle launch pulse to shared modexp engine.
REQ-013 eng_data / eng_exp / eng_mod  out  4*WIDTH / WIDTH / 4*WIDTH  latched operands to engine.
REQ-014 eng_done  in  1  engine completion pulse.
REQ-015 eng_result  in  4*WIDTH  engine result, valid when eng_done=1.
REQ-016 rsp_valid  out  1  response valid.
REQ-017 rsp_ready  in  1  response consumer ready.
REQ-018 rsp_data  out  4*WIDTH  result (zero on error).
REQ-019 rsp_id  out  IDW  index of requester that owns the response.
REQ-020 rsp_err  out  1  1 = job aborted by timeout or invalid operands.

Function
REQ-021 FSM states IDLE, LAUNCH, WAIT, RESP; exactly one job in flight.
REQ-022 IDLE: if any req_valid, grant lowest index at or after rr_ptr (round-robin, wrap at NREQ); assert req_ready[g] for that one cycle; latch operands and g; go LAUNCH.
REQ-023 req_ready is combinational from IDLE state and req_valid; a requester's transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-024 On grant, rr_ptr <= g+1 modulo NREQ.
REQ-025 LAUNCH: if latched modulus is 0 or 1, skip engine, set err, go RESP; else pulse eng_start one cycle, clear timeout counter, go WAIT.
REQ-026 eng_data/eng_exp/eng_mod stay stable from LAUNCH until leaving WAIT.
REQ-027 WAIT: on eng_done capture eng_result, err=0, go RESP; else increment counter; on counter reaching TIMEOUT, err=1, data=0, go RESP.
REQ-028 eng_done outside WAIT is ignored.
REQ-029 RESP: rsp_valid=1 with rsp_data/rsp_id/rsp_err stable until rsp_ready; on handshake go IDLE, rsp_valid=0 next cycle.
REQ-030 Minimum issue-to-issue latency: grant cycle, LAUNCH, >=1 WAIT cycle, RESP cycle; no new grant during LAUNCH/WAIT/RESP.
REQ-031 req_valid deassertion before grant is permitted; no state held per requester other than rr_ptr.

Reset
REQ-032 In reset: state IDLE, rr_ptr 0, counter 0, req_ready 0, eng_start 0, rsp_valid 0, rsp_err 0, rsp_data 0, rsp_id 0, eng operands 0.
REQ-033 Reset mid-job abandons job without response; a later eng_done is ignored per REQ-028.

Structure
REQ-034 FSM state encoding and default WIDTH/NREQ/TIMEOUT constants live in shared package rsa_pkg.
REQ-035 Round-robin selection is one sub-module rr_arbiter (inputs req vector, pointer; outputs one-hot grant, index, any).
REQ-036 Engine is external; this block instantiates no arithmetic.

Verification
REQ-037 Single job: req_valid[2], data=5, exp=3, mod=33; stub engine returns 26 after 10 cycles -> rsp_data=26, rsp_id=2, rsp_err=0.
REQ-038 All four valid continuously from reset -> grant order 0,1,2,3,0; one req_ready pulse each.
REQ-039 Stub never asserts eng_done, TIMEOUT=100 -> rsp_err=1, rsp_data=0 exactly 100 WAIT cycles after eng_start.
REQ-040 mod=1 request -> no eng_start, rsp_err=1 two cycles after grant.
REQ-041 rsp_ready held 0 for 20 cycles -> rsp_valid and fields stable, no new req_ready, no eng_start.
REQ-042 aresetn low during WAIT, stray eng_done after release -> no rsp_valid, all outputs at reset values.
